md_unit: RTL and testbench



---
 rtl/md_unit.sv | 142 ++++++++++++++
 tb/tb_md_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO registers for the Execute stage.
// A long op computes its full result into a shadow register when accepted,
// then commits it to {hi, lo} after a fixed per-family latency. mthi/mtlo
// write immediately. Accumulate ops (madd/msub) fold the product into {hi, lo}.
//
// Handshake: an op is accepted on a rising edge where start && !busy. While
// busy is high start is ignored completely; the hazard unit keeps MD ops in
// Decode until busy drops, so no op is ever lost.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   shadow;

  // Datapath values for the op presented this cycle
  logic signed [2*WIDTH-1:0] sa, sb, prod_s;
  logic        [2*WIDTH-1:0] prod_u, acc, result;
  logic        [WIDTH-1:0]   b_safe, quo_u, rem_u;
  logic signed [WIDTH-1:0]   quo_s, rem_s;
  logic                      is_long;
  logic [CNT_W-1:0]          n_cycles;

  // Compute the full result of the presented op and its latency
  always_comb begin
    sa       = {{WIDTH{a[WIDTH-1]}}, a};
    sb       = {{WIDTH{b[WIDTH-1]}}, b};
    prod_s   = sa * sb;
    prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    acc      = {hi, lo};
    // A zero divisor is replaced so the divider never sees it; that result
    // is discarded anyway.
    b_safe   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    quo_u    = a / b_safe;
    rem_u    = a % b_safe;
    quo_s    = $signed(a) / $signed(b_safe);
    rem_s    = $signed(a) % $signed(b_safe);
    result   = acc;
    is_long  = 1'b0;
    n_cycles = CNT_W'(MULT_CYCLES);
    case (md_op)
      OP_MULT:  begin result = prod_s;       is_long = 1'b1; end
      OP_MULTU: begin result = prod_u;       is_long = 1'b1; end
      OP_MADD:  begin result = acc + prod_s; is_long = 1'b1; end
      OP_MADDU: begin result = acc + prod_u; is_long = 1'b1; end
      OP_MSUB:  begin result = acc - prod_s; is_long = 1'b1; end
      OP_MSUBU: begin result = acc - prod_u; is_long = 1'b1; end
      OP_DIV: begin
        is_long  = 1'b1;
        n_cycles = CNT_W'(DIV_CYCLES);
        // Divide by zero keeps {hi, lo}: hi/lo hold during RUN, so the
        // current value is exactly what commit must write back.
        if (b == '0)
          result = acc;
        else if (a == MIN_NEG && b == ALL_ONES)
          result = {{WIDTH{1'b0}}, MIN_NEG};
        else
          result = {rem_s, quo_s};
      end
      OP_DIVU: begin
        is_long  = 1'b1;
        n_cycles = CNT_W'(DIV_CYCLES);
        result   = (b == '0) ? acc : {rem_u, quo_u};
      end
      default: ;
    endcase
  end

  // Control FSM, countdown and HI/LO / shadow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      shadow <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (md_op == OP_MTHI) begin
              hi <= a;
            end else if (md_op == OP_MTLO) begin
              lo <= a;
            end else if (is_long) begin
              shadow <= result;
              cnt    <= n_cycles;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (cnt <= CNT_W'(1)) begin
            {hi, lo} <= shadow;
            cnt      <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: multiply, divide, move-to, accumulate,
// ignored start, back-to-back issue, async reset mid-op and the N=1 latency.
module tb_md_unit;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_f = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, busy_f;
  logic [31:0] hi, lo, hi_f, lo_f;

  int tests = 0;
  int fails = 0;

  // clock / reset
  always #5 clk = ~clk;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  // Short-latency instance for the single-cycle busy boundary
  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(2), .CNT_W(4)) dut_fast (
    .clk(clk), .reset(reset), .start(start_f), .md_op(md_op),
    .a(a), .b(b), .busy(busy_f), .hi(hi_f), .lo(lo_f)
  );

  // Driver: present op for one edge (called at a negedge), then count busy
  // cycles at negedges until busy drops, bounded.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int cyc);
    start = 1'b1; md_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++;
      $display("FAIL reset_hilo got hi=%h lo=%h want 0/0", hi, lo); end
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int cyc;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, cyc);
    tests++; if (cyc !== 5) begin fails++;
      $display("FAIL mult_busy_cycles got %0d want 5", cyc); end
    tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin fails++;
      $display("FAIL mult_result got %h_%h want ffffffff_fffffffa", hi, lo); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, cyc);
    tests++; if (cyc !== 5 || hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin fails++;
      $display("FAIL multu got cyc=%0d %h_%h want 5 00000001_fffffffe", cyc, hi, lo); end
  endtask

  task automatic test_div();
    int cyc;
    logic [31:0] hold_hi, hold_lo;
    // Holding during RUN: sample part way through
    start = 1'b1; md_op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    @(negedge clk);
    tests++; if (busy !== 1'b1 || hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin fails++;
      $display("FAIL div_hold_run got busy=%b %h_%h want 1 00000001_fffffffe", busy, hi, lo); end
    cyc = 2;
    while (busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    cyc--;
    tests++; if (cyc !== 10) begin fails++;
      $display("FAIL div_busy_cycles got %0d want 10", cyc); end
    tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin fails++;
      $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo); end
    hold_hi = hi; hold_lo = lo;
    run_op(OP_DIVU, 32'd5, 32'd0, cyc);
    tests++; if (cyc !== 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin fails++;
      $display("FAIL divu_zero got cyc=%0d %h_%h want 10 %h_%h", cyc, hi, lo, hold_hi, hold_lo); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    tests++; if (hi !== 32'h0 || lo !== 32'h8000_0000) begin fails++;
      $display("FAIL div_overflow got %h_%h want 00000000_80000000", hi, lo); end
    run_op(OP_DIVU, 32'd100, 32'd7, cyc);
    tests++; if (hi !== 32'd2 || lo !== 32'd14) begin fails++;
      $display("FAIL divu got %h_%h want 00000002_0000000e", hi, lo); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, cyc);
    tests++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin fails++;
      $display("FAIL div_negdivisor got %h_%h want 00000001_fffffffd", hi, lo); end
  endtask

  task automatic test_move_acc();
    int cyc;
    run_op(OP_MTHI, 32'h1, 32'h0, cyc);
    tests++; if (cyc !== 0 || hi !== 32'h1) begin fails++;
      $display("FAIL mthi got cyc=%0d hi=%h want 0 00000001", cyc, hi); end
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, cyc);
    tests++; if (cyc !== 0 || lo !== 32'hFFFF_FFFF || hi !== 32'h1) begin fails++;
      $display("FAIL mtlo got cyc=%0d %h_%h want 0 00000001_ffffffff", cyc, hi, lo); end
    run_op(OP_MADDU, 32'd1, 32'd1, cyc);
    tests++; if (cyc !== 5 || hi !== 32'd2 || lo !== 32'd0) begin fails++;
      $display("FAIL maddu got cyc=%0d %h_%h want 5 00000002_00000000", cyc, hi, lo); end
    run_op(OP_MSUB, 32'd1, 32'd1, cyc);
    tests++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFF) begin fails++;
      $display("FAIL msub got %h_%h want 00000001_ffffffff", hi, lo); end
    run_op(OP_MADD, 32'hFFFF_FFFF, 32'd2, cyc);
    tests++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin fails++;
      $display("FAIL madd_neg got %h_%h want 00000001_fffffffd", hi, lo); end
    run_op(OP_MSUBU, 32'hFFFF_FFFF, 32'd1, cyc);
    tests++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFE) begin fails++;
      $display("FAIL msubu got %h_%h want 00000000_fffffffe", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start = 1'b1; md_op = OP_MULT; a = 32'd2; b = 32'd3;
    @(negedge clk);
    // Conflicting start while busy must be ignored
    md_op = OP_MULT; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    cyc = 2;
    while (busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    cyc--;
    tests++; if (cyc !== 5 || hi !== 32'd0 || lo !== 32'd6) begin fails++;
      $display("FAIL ignored_start got cyc=%0d %h_%h want 5 00000000_00000006", cyc, hi, lo); end
    // Issue in the very cycle busy has fallen: accumulates on committed value
    run_op(OP_MADDU, 32'd1, 32'd4, cyc);
    tests++; if (cyc !== 5 || hi !== 32'd0 || lo !== 32'd10) begin fails++;
      $display("FAIL back_to_back got cyc=%0d %h_%h want 5 00000000_0000000a", cyc, hi, lo); end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    run_op(OP_MTHI, 32'h55, 32'h0, cyc);
    start = 1'b1; md_op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin fails++;
      $display("FAIL reset_async got busy=%b %h_%h want 0 0_0", busy, hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    tests++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin fails++;
      $display("FAIL reset_no_commit got busy=%b %h_%h want 0 0_0", busy, hi, lo); end
  endtask

  task automatic test_single_cycle();
    int cyc;
    start_f = 1'b1; md_op = OP_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start_f = 1'b0; md_op = 4'd0;
    cyc = 0;
    while (busy_f === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    tests++; if (cyc !== 1 || hi_f !== 32'd0 || lo_f !== 32'd12) begin fails++;
      $display("FAIL n1_mult got cyc=%0d %h_%h want 1 00000000_0000000c", cyc, hi_f, lo_f); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_move_acc();
    test_back_to_back();
    test_reset_mid_op();
    test_single_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
